// File: rtl/serv_rf_ram_resp_if.sv
// Word-wide SERV register-file SRAM port: write/read requests from the core,
// registered read data and status back from the RAM side.
interface serv_rf_ram_resp_if #(
   parameter int width = 8,
   parameter int aw    = 8
);
   logic [aw-1:0]    i_waddr;
   logic [width-1:0] i_wdata;
   logic             i_wen;
   logic [aw-1:0]    i_raddr;
   logic             i_ren;
   logic [width-1:0] o_rdata;
   logic             o_init_done;
   logic             o_err;

   modport master (
      output i_waddr, i_wdata, i_wen, i_raddr, i_ren,
      input  o_rdata, o_init_done, o_err
   );

   modport slave (
      input  i_waddr, i_wdata, i_wen, i_raddr, i_ren,
      output o_rdata, o_init_done, o_err
   );
endinterface

// File: rtl/serv_rf_ram_resp.sv
// RAM-side responder for the SERV register file: flop array with one-cycle
// read latency, write-first bypass, and a post-reset clear sequencer.
//
// state | meaning
// CLEAR | zeroing mem[ccnt] once per cycle; requests ignored, o_init_done low
// RUN   | serving reads/writes; o_init_done high until the next reset
module serv_rf_ram_resp #(
   parameter int width    = 8,
   parameter int csr_regs = 4,
   parameter int depth    = (32 + csr_regs) * 32 / width,
   parameter int aw       = $clog2(depth)
) (
   input logic               i_clk,
   input logic               i_rst,
   serv_rf_ram_resp_if.slave bus
);

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } state_t;

   localparam logic [aw-1:0] last_addr = aw'(depth - 1);

   logic [width-1:0] mem [depth];

   state_t           state;
   logic [aw-1:0]    ccnt;
   logic [width-1:0] rdata;
   logic             init_done;
   logic             err;

   logic             waddr_ok;
   logic             raddr_ok;
   logic             mem_we;
   logic [aw-1:0]    mem_wa;
   logic [width-1:0] mem_wd;

   assign waddr_ok = (bus.i_waddr <= last_addr);
   assign raddr_ok = (bus.i_raddr <= last_addr);

   // The clear sequencer owns the single write port until RUN.
   always_comb begin
      mem_we = 1'b0;
      mem_wa = '0;
      mem_wd = '0;
      if (state == CLEAR) begin
         mem_we = 1'b1;
         mem_wa = ccnt;
      end else begin
         mem_we = bus.i_wen & waddr_ok;
         mem_wa = bus.i_waddr;
         mem_wd = bus.i_wdata;
      end
   end

   always_ff @(posedge i_clk) begin
      if (mem_we)
         mem[mem_wa] <= mem_wd;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state     <= CLEAR;
         ccnt      <= '0;
         rdata     <= '0;
         init_done <= 1'b0;
         err       <= 1'b0;
      end else begin
         case (state)
            CLEAR: begin
               rdata <= '0;
               ccnt  <= ccnt + 1'b1;
               if (ccnt == last_addr) begin
                  state     <= RUN;
                  init_done <= 1'b1;
               end
            end
            RUN: begin
               if (bus.i_ren) begin
                  if (!raddr_ok)
                     rdata <= '0;
                  else if (bus.i_wen && (bus.i_waddr == bus.i_raddr))
                     rdata <= bus.i_wdata;
                  else
                     rdata <= mem[bus.i_raddr];
               end
               if ((bus.i_wen && !waddr_ok) || (bus.i_ren && !raddr_ok))
                  err <= 1'b1;
            end
            default: state <= CLEAR;
         endcase
      end
   end

   assign bus.o_rdata     = rdata;
   assign bus.o_init_done = init_done;
   assign bus.o_err       = err;

endmodule

// File: tb/tb_serv_rf_ram_resp.sv
// Bench for serv_rf_ram_resp (width=8, csr_regs=4 -> depth 144): vector table
// through a scoreboard queue, plus hand-written reset/clear sequences.
module tb_serv_rf_ram_resp;

   logic clk = 1'b0;
   logic rst = 1'b0;

   always #5 clk = ~clk;

   serv_rf_ram_resp_if #(.width(8), .aw(8)) bus ();

   serv_rf_ram_resp #(.width(8), .csr_regs(4)) dut (
      .i_clk(clk),
      .i_rst(rst),
      .bus  (bus)
   );

   typedef struct {
      logic       wen;
      logic [7:0] waddr;
      logic [7:0] wdata;
      logic       ren;
      logic [7:0] raddr;
      logic [7:0] exp_rdata;
      logic       exp_err;
   } vec_t;

   typedef struct {
      logic [7:0] rdata;
      logic       err;
      string      name;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   function automatic vec_t mk(input logic wen, input logic [7:0] waddr, input logic [7:0] wdata,
                               input logic ren, input logic [7:0] raddr,
                               input logic [7:0] er, input logic ee);
      vec_t v;
      v.wen = wen; v.waddr = waddr; v.wdata = wdata;
      v.ren = ren; v.raddr = raddr; v.exp_rdata = er; v.exp_err = ee;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic set_inputs(input logic wen, input logic [7:0] waddr, input logic [7:0] wdata,
                             input logic ren, input logic [7:0] raddr);
      bus.i_wen   = wen;
      bus.i_waddr = waddr;
      bus.i_wdata = wdata;
      bus.i_ren   = ren;
      bus.i_raddr = raddr;
   endtask

   task automatic drive(input vec_t v, input string name);
      exp_t e;
      set_inputs(v.wen, v.waddr, v.wdata, v.ren, v.raddr);
      e.rdata = v.exp_rdata;
      e.err   = v.exp_err;
      e.name  = name;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check({e.name, " rdata"}, 32'(bus.o_rdata), 32'(e.rdata));
      check({e.name, " err"}, 32'(bus.o_err), 32'(e.err));
   endtask

   task automatic wait_init(output int n);
      n = 0;
      while (!bus.o_init_done && n < 1000) begin
         @(posedge clk);
         #1;
         n++;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      set_inputs(1'b0, 8'd0, 8'd0, 1'b0, 8'd0);

      #1 rst = 1'b1;
      #1;
      check("reset init_done", 32'(bus.o_init_done), 32'd0);
      check("reset rdata", 32'(bus.o_rdata), 32'd0);
      check("reset err", 32'(bus.o_err), 32'd0);

      @(posedge clk);
      #1 rst = 1'b0;
      wait_init(n);
      check("init cycles", 32'(n), 32'd144);

      vecs.push_back(mk(1'b0, 8'd0,   8'h00, 1'b1, 8'd0,   8'h00, 1'b0));
      vecs.push_back(mk(1'b0, 8'd0,   8'h00, 1'b1, 8'd77,  8'h00, 1'b0));
      vecs.push_back(mk(1'b0, 8'd0,   8'h00, 1'b1, 8'd143, 8'h00, 1'b0));
      vecs.push_back(mk(1'b1, 8'd10,  8'hA5, 1'b0, 8'd0,   8'h00, 1'b0));
      vecs.push_back(mk(1'b0, 8'd0,   8'h00, 1'b1, 8'd10,  8'hA5, 1'b0));
      vecs.push_back(mk(1'b0, 8'd0,   8'h00, 1'b0, 8'd0,   8'hA5, 1'b0));
      vecs.push_back(mk(1'b0, 8'd0,   8'h00, 1'b0, 8'd10,  8'hA5, 1'b0));
      vecs.push_back(mk(1'b1, 8'd20,  8'h3C, 1'b1, 8'd20,  8'h3C, 1'b0));
      vecs.push_back(mk(1'b0, 8'd0,   8'h00, 1'b1, 8'd20,  8'h3C, 1'b0));
      vecs.push_back(mk(1'b1, 8'd6,   8'h22, 1'b0, 8'd0,   8'h3C, 1'b0));
      vecs.push_back(mk(1'b1, 8'd5,   8'h11, 1'b1, 8'd6,   8'h22, 1'b0));
      vecs.push_back(mk(1'b0, 8'd0,   8'h00, 1'b1, 8'd5,   8'h11, 1'b0));
      vecs.push_back(mk(1'b1, 8'd143, 8'h5A, 1'b0, 8'd0,   8'h11, 1'b0));
      vecs.push_back(mk(1'b0, 8'd0,   8'h00, 1'b1, 8'd143, 8'h5A, 1'b0));
      vecs.push_back(mk(1'b1, 8'd200, 8'hFF, 1'b0, 8'd0,   8'h5A, 1'b1));
      vecs.push_back(mk(1'b0, 8'd0,   8'h00, 1'b1, 8'd200, 8'h00, 1'b1));
      vecs.push_back(mk(1'b0, 8'd0,   8'h00, 1'b1, 8'd10,  8'hA5, 1'b1));
      vecs.push_back(mk(1'b0, 8'd0,   8'h00, 1'b0, 8'd0,   8'hA5, 1'b1));

      foreach (vecs[i])
         drive(vecs[i], $sformatf("vec%0d", i));

      // Fill 0..3, then reset while a read is in flight.
      for (int a = 0; a < 4; a++)
         drive(mk(1'b1, 8'(a), 8'(8'h10 + a), 1'b0, 8'd0, 8'hA5, 1'b1), $sformatf("fill%0d", a));
      drive(mk(1'b0, 8'd0, 8'h00, 1'b1, 8'd3, 8'h13, 1'b1), "fill rd3");

      set_inputs(1'b0, 8'd0, 8'h00, 1'b1, 8'd2);
      @(posedge clk);
      #1;
      check("pre-reset rdata", 32'(bus.o_rdata), 32'h12);
      #2 rst = 1'b1;
      #1;
      check("midrst init_done", 32'(bus.o_init_done), 32'd0);
      check("midrst rdata", 32'(bus.o_rdata), 32'd0);
      check("midrst err", 32'(bus.o_err), 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;

      // Requests during CLEAR, including out-of-range ones, must have no effect.
      n = 0;
      while (!bus.o_init_done && n < 1000) begin
         if (n % 2 == 0)
            set_inputs(1'b1, 8'(n % 4), 8'hEE, 1'b1, 8'(n % 4));
         else
            set_inputs(1'b1, 8'd200, 8'hEE, 1'b1, 8'd210);
         @(posedge clk);
         #1;
         n++;
         check($sformatf("clear%0d rdata", n), 32'(bus.o_rdata), 32'd0);
         check($sformatf("clear%0d err", n), 32'(bus.o_err), 32'd0);
      end
      set_inputs(1'b0, 8'd0, 8'h00, 1'b0, 8'd0);
      check("reinit cycles", 32'(n), 32'd144);

      for (int a = 0; a < 4; a++)
         drive(mk(1'b0, 8'd0, 8'h00, 1'b1, 8'(a), 8'h00, 1'b0), $sformatf("post%0d", a));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/serv_rf_ram_resp.md
Name: serv_rf_ram_resp

Overview:
RAM-side responder for the SERV register-file SRAM interface. It accepts the word-wide write and read requests (waddr/wdata/wen, raddr/ren) that the SERV RF interface issues. It returns read data with exactly one cycle of latency. Storage is a flop-based array sized for 32 GPRs plus CSR slots. After reset, a clear sequencer zeroes every word before signalling ready, so the core never reads undefined register contents.

Parameters:
width, 8, data width of the RAM port in bits; must be a power of two, 2..32.
csr_regs, 4, number of CSR registers stored after the 32 GPRs.
depth, (32+csr_regs)*32/width, number of words; derived, do not override.
aw, $clog2(depth), address width; derived, do not override.

Ports:
i_clk  in  1  clock; all state changes on the rising edge.
i_rst  in  1  asynchronous, active-high reset.
i_waddr  in  aw  write word address.
i_wdata  in  width  write data.
i_wen  in  1  write strobe, one word per cycle.
i_raddr  in  aw  read word address.
i_ren  in  1  read strobe.
o_rdata  out  width  registered read data, valid the cycle after i_ren.
o_init_done  out  1  high once the clear sequence has completed; SERV is held in reset until then.
o_err  out  1  sticky flag; set on any access to an address >= depth.

Behaviour:
- Reset (asynchronous, active-high, effective immediately on assertion):
  - state=CLEAR, clear counter ccnt=0.
  - o_rdata=0, o_init_done=0, o_err=0.
  - Array contents are not reset directly; the clear sequencer zeroes them.
- FSM has two states:
  - CLEAR: each cycle writes 0 to mem[ccnt], then ccnt<=ccnt+1. When ccnt==depth-1 has been written, go to RUN. Clearing takes exactly depth cycles after reset deassertion.
  - RUN: o_init_done=1. No further transitions except via reset.
- In CLEAR, i_wen, i_ren, i_waddr and i_raddr are ignored. o_rdata holds 0 and o_err is not updated.
- Write (RUN): if i_wen and i_waddr<depth, mem[i_waddr]<=i_wdata at the clock edge.
- Read (RUN): if i_ren, o_rdata<=mem[i_raddr] at the edge, so data is visible one cycle after the request. If i_ren=0, o_rdata holds its previous value; the interface samples it on later cycles.
- Simultaneous i_wen and i_ren to the same address (write-first): o_rdata<=i_wdata, and the array is also updated.
- Write and read to different addresses in the same cycle: both proceed independently.
- Back-to-back read after write (write in cycle N, read the same address in cycle N+1): returns the new data. This follows naturally from the array update; no extra pipeline is needed.
- Out-of-range access (address >= depth, possible when depth is not a power of two):
  - Write: dropped.
  - Read: o_rdata<=0.
  - Either case sets o_err<=1; it stays set until reset.
- Reset asserted mid-operation (CLEAR or RUN): immediately returns to the reset values above, and the full clear sequence reruns after deassertion.
- No reads or writes are lost in RUN. The block is always ready and never stalls.
- Widths: ccnt is aw bits and compared against depth-1. Address compares are unsigned.

Test Plan:
- Reset, then deassert with width=8, csr_regs=4 (depth=144, aw=8) -> o_init_done rises exactly 144 cycles after deassertion. Afterwards, reads of addresses 0, 77 and 143 return 0x00.
- RUN: write 0xA5 to addr 10, then set i_ren at addr 10 the next cycle -> o_rdata=0xA5 one cycle after i_ren. With i_ren low on following cycles, o_rdata stays 0xA5.
- Same-cycle i_wen and i_ren at addr 20 with i_wdata=0x3C (old contents 0x00) -> next cycle o_rdata=0x3C. A later read of addr 20 also returns 0x3C.
- Same-cycle write of 0x11 to addr 5 and read of addr 6 (holding 0x22) -> o_rdata=0x22, and addr 5 then reads 0x11.
- Write 0xFF to addr 200 -> o_err=1 and the write is dropped. A read of addr 200 returns 0x00. o_err remains 1 until reset.
- Fill addr 0..3 with nonzero data, assert i_rst mid-stream for one cycle -> o_init_done and o_rdata go to 0 at once. After a fresh 144-cycle clear, addr 0..3 read 0x00. Requests issued during CLEAR have no effect.
